fetch_sequencer: RTL



---
 rtl/fetch_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//
// Sequences the architectural PC of the Monociclo core across a handshaked
// instruction-memory fetch.
//
// Flow:
//   IDLE -> FETCH -> ISSUE -> EXEC -> FETCH ...
//   The PC advances by 4 or takes a redirect when execute completes.
//   HALTED and ERROR are terminal until reset.
//
// Optional feature (compile-time macro FETCH_TIMEOUT_EN):
//   Aborts a fetch that waits TIMEOUT_CYCLES cycles without i_imem_ready.
//   The sequencer then reports err_code 2'b10.
//   With the macro undefined, FETCH waits indefinitely.
//
// Parameters:
//   RESET_VECTOR    PC after reset; bits [1:0] are forced to zero.
//   TIMEOUT_CYCLES  fetch wait limit, 1..65535. Only used with FETCH_TIMEOUT_EN.
//
// Ports:
//   i_clk               rising-edge clock
//   i_rst_n             asynchronous active-low reset
//   o_imem_req          fetch request; high for the whole FETCH state
//   o_imem_addr         fetch address; always equal to o_pc
//   i_imem_ready        fetch response valid; sampled only in FETCH
//   i_imem_rdata        fetched instruction word
//   o_instr_valid       one-cycle pulse; o_instr and o_instr_pc are valid
//   o_instr             captured instruction word
//   o_instr_pc          PC of the captured instruction
//   i_exec_done         issued instruction finished; sampled only in EXEC
//   i_redirect          taken branch/jump; qualified by i_exec_done
//   i_redirect_target   next PC when i_redirect=1
//   i_halt              stop request; qualified by i_exec_done
//   o_pc                current architectural PC
//   o_halted            sticky halt flag
//   o_error             sticky fault flag
//   o_err_code          01 misaligned redirect, 10 fetch timeout, 00 none
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_valid,
  output logic [31:0] o_instr,
  output logic [31:0] o_instr_pc,
  input  logic        i_exec_done,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_target,
  input  logic        i_halt,
  output logic [31:0] o_pc,
  output logic        o_halted,
  output logic        o_error,
  output logic [1:0]  o_err_code
);

  localparam logic [31:0] RESET_PC = {RESET_VECTOR[31:2], 2'b00};

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_MISALIGN  = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b10;

  // Reject an out-of-range wait limit at elaboration.
  if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
    $error("fetch_sequencer: TIMEOUT_CYCLES must be in 1..65535");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_ISSUE  = 3'd2,
    S_EXEC   = 3'd3,
    S_HALTED = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_imem_req;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_halted;
  logic        r_error;
  logic [1:0]  r_err_code;

`ifdef FETCH_TIMEOUT_EN
  // The abort fires on the edge that closes the TIMEOUT_CYCLES-th empty wait cycle.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wait_cnt;
`endif

  logic [31:0] w_pc_seq;
  logic        w_target_misaligned;

  assign w_pc_seq            = r_pc + 32'd4;  // wraps modulo 2^32
  assign w_target_misaligned = (i_redirect_target[1:0] != 2'b00);

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_imem_req    <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= 32'h0000_0000;
      r_instr_pc    <= 32'h0000_0000;
      r_halted      <= 1'b0;
      r_error       <= 1'b0;
      r_err_code    <= ERR_NONE;
`ifdef FETCH_TIMEOUT_EN
      r_wait_cnt    <= 16'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_imem_req <= 1'b1;
          r_state    <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
          r_wait_cnt <= 16'd0;
`endif
        end

        S_FETCH: begin
          // A response on the limit cycle still wins over the timeout.
          if (i_imem_ready) begin
            r_instr       <= i_imem_rdata;
            r_instr_pc    <= r_pc;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b1;
            r_state       <= S_ISSUE;
          end
`ifdef FETCH_TIMEOUT_EN
          else if (r_wait_cnt == TIMEOUT_LAST) begin
            r_imem_req <= 1'b0;
            r_error    <= 1'b1;
            r_err_code <= ERR_TIMEOUT;
            r_state    <= S_ERROR;
          end else begin
            r_wait_cnt <= r_wait_cnt + 16'd1;
          end
`else
          else begin
            r_state <= S_FETCH;
          end
`endif
        end

        S_ISSUE: begin
          r_instr_valid <= 1'b0;
          r_state       <= S_EXEC;
        end

        S_EXEC: begin
          if (i_exec_done) begin
            // Priority: halt, then redirect, then sequential.
            if (i_halt) begin
              r_halted <= 1'b1;
              r_state  <= S_HALTED;
            end else if (i_redirect && w_target_misaligned) begin
              r_error    <= 1'b1;
              r_err_code <= ERR_MISALIGN;
              r_state    <= S_ERROR;
            end else begin
              r_pc       <= i_redirect ? i_redirect_target : w_pc_seq;
              r_imem_req <= 1'b1;
              r_state    <= S_FETCH;
`ifdef FETCH_TIMEOUT_EN
              r_wait_cnt <= 16'd0;
`endif
            end
          end else begin
            r_state <= S_EXEC;
          end
        end

        S_HALTED: r_state <= S_HALTED;
        S_ERROR:  r_state <= S_ERROR;

        default: begin
          // An illegal encoding parks the sequencer in ERROR rather than fetching.
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
          r_state       <= S_ERROR;
        end
      endcase
    end
  end

  assign o_imem_req    = r_imem_req;
  assign o_imem_addr   = r_pc;
  assign o_pc          = r_pc;
  assign o_instr_valid = r_instr_valid;
  assign o_instr       = r_instr;
  assign o_instr_pc    = r_instr_pc;
  assign o_halted      = r_halted;
  assign o_error       = r_error;
  assign o_err_code    = r_err_code;

endmodule
